// File: rtl/df_ctrl_pkg.sv
// Shared types and constants for the dataflow controller.
// Holds the tile-walker loop order, limit/step groupings and the dimension and
// stream index map used by df_tile_iter and df_loop_cnt.
package df_ctrl_pkg;

   localparam int NUM_TILE_DIMS    = 4;
   localparam int NUM_TILE_STREAMS = 3;

   localparam int TILE_CNT_W  = 16;
   localparam int TILE_ADDR_W = 32;

   // Dimension slots, matching the {c,k,y,x} packing of the limit bus.
   localparam int DIM_X = 0;
   localparam int DIM_Y = 1;
   localparam int DIM_K = 2;
   localparam int DIM_C = 3;

   // Stream slots inside each dimension's offset bank.
   localparam int STR_PSUMS   = 0;
   localparam int STR_IFMAPS  = 1;
   localparam int STR_WEIGHTS = 2;

   typedef enum logic {
      LOOP_C_INNER = 1'b0,
      LOOP_C_OUTER = 1'b1
   } loop_order_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } tile_state_e;

   typedef struct packed {
      logic [TILE_CNT_W-1:0] c;
      logic [TILE_CNT_W-1:0] k;
      logic [TILE_CNT_W-1:0] y;
      logic [TILE_CNT_W-1:0] x;
   } TileIterLims;

   // psums {k,y,x}, ifmaps {c,y,x}, weights {c,k}; index 0 is the LSB group.
   typedef struct packed {
      logic [2:0][TILE_ADDR_W-1:0] psums;
      logic [2:0][TILE_ADDR_W-1:0] ifmaps;
      logic [1:0][TILE_ADDR_W-1:0] weights;
   } TileIterSteps;

endpackage

// File: rtl/df_loop_cnt.sv
// One loop dimension of the tile walker: index counter, wrap detect and one
// address offset accumulator per stream. A stream that ignores this dimension
// is fed a zero step, so its offset stays at zero.
module df_loop_cnt
   import df_ctrl_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int ADDR_W      = 32,
   parameter int NUM_STREAMS = 3
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic                                i_clr,
   input  logic                                i_inc,
   input  logic [CNT_W-1:0]                    i_lim,
   input  logic [NUM_STREAMS-1:0][ADDR_W-1:0]  i_step,
   output logic                                o_at_lim,
   output logic                                o_at_zero,
   output logic [NUM_STREAMS-1:0][ADDR_W-1:0]  o_offs
);

   logic [CNT_W-1:0]                   cnt_q;
   logic [NUM_STREAMS-1:0][ADDR_W-1:0] offs_q;

   assign o_at_lim  = (cnt_q == i_lim);
   assign o_at_zero = (cnt_q == '0);
   assign o_offs    = offs_q;

   // Step or wrap the index and all stream offsets together.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q  <= '0;
         offs_q <= '0;
      end else if (i_clr) begin
         cnt_q  <= '0;
         offs_q <= '0;
      end else if (i_inc) begin
         if (o_at_lim) begin
            cnt_q  <= '0;
            offs_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            for (int s = 0; s < NUM_STREAMS; s++) begin
               offs_q[s] <= offs_q[s] + i_step[s];
            end
         end
      end
   end

endmodule

// File: rtl/df_tile_iter.sv
// Tile-loop walker: emits one psums/ifmaps/weights descriptor per handshake,
// walking the x/y/k/c loop nest in one of two orders.
// Optional macro DF_TILE_ITER_PERF_EN adds a saturating stall counter on
// o_stall_cnt; without it the port is tied to zero.
//
// state   | meaning
// IDLE    | waiting for i_start, config not yet latched
// RUN     | presenting descriptors, advancing on each handshake
// DONE    | one-cycle o_done pulse after the final handshake
module df_tile_iter
   import df_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic                i_order,
   input  logic [4*CNT_W-1:0]  i_lim,
   input  logic [ADDR_W-1:0]   i_psums_base,
   input  logic [ADDR_W-1:0]   i_ifmaps_base,
   input  logic [ADDR_W-1:0]   i_weights_base,
   input  logic [3*ADDR_W-1:0] i_psums_step,
   input  logic [3*ADDR_W-1:0] i_ifmaps_step,
   input  logic [2*ADDR_W-1:0] i_weights_step,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [ADDR_W-1:0]   o_psums_addr,
   output logic [ADDR_W-1:0]   o_ifmaps_addr,
   output logic [ADDR_W-1:0]   o_weights_addr,
   output logic                o_first_c,
   output logic                o_last_c,
   output logic                o_last,
   output logic                o_busy,
   output logic                o_done,
   output logic [31:0]         o_stall_cnt
);

   localparam int NS = NUM_TILE_STREAMS;

   tile_state_e         state_q;
   loop_order_e         order_q;
   logic                valid_q;
   logic                done_q;
   logic [4*CNT_W-1:0]  lim_q;
   logic [ADDR_W-1:0]   psums_base_q, ifmaps_base_q, weights_base_q;
   logic [3*ADDR_W-1:0] psums_step_q, ifmaps_step_q;
   logic [2*ADDR_W-1:0] weights_step_q;

   logic [NUM_TILE_DIMS-1:0]                  dim_inc, dim_at_lim, dim_at_zero;
   logic [NUM_TILE_DIMS-1:0][NS-1:0][ADDR_W-1:0] dim_step, dim_offs;
   logic start_acc, hs, all_lim;
   logic inc_x, inc_y, inc_k, inc_c;
   logic unused_at_zero;

   assign start_acc      = (state_q == ST_IDLE) & i_start;
   assign hs             = valid_q & i_ready & ~i_abort;
   assign all_lim        = &dim_at_lim;
   assign unused_at_zero = &dim_at_zero[DIM_K:DIM_X];

   // Control FSM; also latches the walk configuration on an accepted start.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q        <= ST_IDLE;
         order_q        <= LOOP_C_INNER;
         valid_q        <= 1'b0;
         done_q         <= 1'b0;
         lim_q          <= '0;
         psums_base_q   <= '0;
         ifmaps_base_q  <= '0;
         weights_base_q <= '0;
         psums_step_q   <= '0;
         ifmaps_step_q  <= '0;
         weights_step_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  state_q        <= ST_RUN;
                  valid_q        <= 1'b1;
                  order_q        <= loop_order_e'(i_order);
                  lim_q          <= i_lim;
                  psums_base_q   <= i_psums_base;
                  ifmaps_base_q  <= i_ifmaps_base;
                  weights_base_q <= i_weights_base;
                  psums_step_q   <= i_psums_step;
                  ifmaps_step_q  <= i_ifmaps_step;
                  weights_step_q <= i_weights_step;
               end
            end
            ST_RUN: begin
               if (i_abort) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
               end else if (hs && all_lim) begin
                  state_q <= ST_DONE;
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Carry chain: the innermost dim steps on every handshake, each outer dim
   // steps when everything inside it is at its limit.
   always_comb begin
      inc_x = 1'b0;
      inc_y = 1'b0;
      inc_k = 1'b0;
      inc_c = 1'b0;
      if (order_q == LOOP_C_INNER) begin
         inc_c = hs;
         inc_x = inc_c & dim_at_lim[DIM_C];
         inc_y = inc_x & dim_at_lim[DIM_X];
         inc_k = inc_y & dim_at_lim[DIM_Y];
      end else begin
         inc_x = hs;
         inc_y = inc_x & dim_at_lim[DIM_X];
         inc_c = inc_y & dim_at_lim[DIM_Y];
         inc_k = inc_c & dim_at_lim[DIM_C];
      end
   end

   assign dim_inc = {inc_c, inc_k, inc_y, inc_x};

   // Route each stream's steps to the dims it depends on; the rest stay zero.
   always_comb begin
      dim_step = '0;
      dim_step[DIM_X][STR_PSUMS]   = psums_step_q[0 +: ADDR_W];
      dim_step[DIM_Y][STR_PSUMS]   = psums_step_q[ADDR_W +: ADDR_W];
      dim_step[DIM_K][STR_PSUMS]   = psums_step_q[2*ADDR_W +: ADDR_W];
      dim_step[DIM_X][STR_IFMAPS]  = ifmaps_step_q[0 +: ADDR_W];
      dim_step[DIM_Y][STR_IFMAPS]  = ifmaps_step_q[ADDR_W +: ADDR_W];
      dim_step[DIM_C][STR_IFMAPS]  = ifmaps_step_q[2*ADDR_W +: ADDR_W];
      dim_step[DIM_K][STR_WEIGHTS] = weights_step_q[0 +: ADDR_W];
      dim_step[DIM_C][STR_WEIGHTS] = weights_step_q[ADDR_W +: ADDR_W];
   end

   for (genvar d = 0; d < NUM_TILE_DIMS; d++) begin : g_dim
      df_loop_cnt #(
         .CNT_W       (CNT_W),
         .ADDR_W      (ADDR_W),
         .NUM_STREAMS (NS)
      ) u_cnt (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_clr     (start_acc),
         .i_inc     (dim_inc[d]),
         .i_lim     (lim_q[d*CNT_W +: CNT_W]),
         .i_step    (dim_step[d]),
         .o_at_lim  (dim_at_lim[d]),
         .o_at_zero (dim_at_zero[d]),
         .o_offs    (dim_offs[d])
      );
   end

   // Address = base + sum of that stream's offsets, wrapping mod 2^ADDR_W.
   always_comb begin
      o_psums_addr   = psums_base_q;
      o_ifmaps_addr  = ifmaps_base_q;
      o_weights_addr = weights_base_q;
      for (int d = 0; d < NUM_TILE_DIMS; d++) begin
         o_psums_addr   = o_psums_addr   + dim_offs[d][STR_PSUMS];
         o_ifmaps_addr  = o_ifmaps_addr  + dim_offs[d][STR_IFMAPS];
         o_weights_addr = o_weights_addr + dim_offs[d][STR_WEIGHTS];
      end
   end

   // Flags are qualified by o_valid so they read zero outside a descriptor.
   assign o_valid   = valid_q;
   assign o_first_c = valid_q & dim_at_zero[DIM_C];
   assign o_last_c  = valid_q & dim_at_lim[DIM_C];
   assign o_last    = valid_q & all_lim;
   assign o_busy    = (state_q != ST_IDLE);
   assign o_done    = done_q;

`ifdef DF_TILE_ITER_PERF_EN
   logic [31:0] stall_q;

   // Count back-pressure cycles of the current walk, saturating.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_q <= '0;
      end else if (start_acc) begin
         stall_q <= '0;
      end else if (valid_q && !i_ready && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign o_stall_cnt = stall_q;
`else
   assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_df_tile_iter.sv
// Bench for df_tile_iter: behavioural model of the loop nest (tile list built
// by mixed-radix decode and multiplication), a per-cycle compare process and
// directed literal checks for the key scenarios.
module tb_df_tile_iter;
   import df_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic i_rst = 1'b1, i_start = 1'b0, i_abort = 1'b0, i_order = 1'b0, i_ready = 1'b0;
   TileIterLims  lims_s  = '0;
   TileIterSteps steps_s = '0;
   logic [31:0] pb = '0, ib = '0, wb = '0;

   logic        o_valid, o_first_c, o_last_c, o_last, o_busy, o_done;
   logic [31:0] o_psums_addr, o_ifmaps_addr, o_weights_addr, o_stall_cnt;

   df_tile_iter dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
      .i_order(i_order), .i_lim(lims_s),
      .i_psums_base(pb), .i_ifmaps_base(ib), .i_weights_base(wb),
      .i_psums_step(steps_s.psums), .i_ifmaps_step(steps_s.ifmaps),
      .i_weights_step(steps_s.weights),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_psums_addr(o_psums_addr), .o_ifmaps_addr(o_ifmaps_addr),
      .o_weights_addr(o_weights_addr), .o_first_c(o_first_c),
      .o_last_c(o_last_c), .o_last(o_last), .o_busy(o_busy),
      .o_done(o_done), .o_stall_cnt(o_stall_cnt)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [31:0] p, i, w;
      bit          fc, lc;
   } tile_t;

   tile_t       exp_q[$];
   int          phase = 0;       // 0 idle, 1 presenting tiles, 2 done pulse
   logic [31:0] m_stall = '0;
   int          done_cnt = 0;
   logic [31:0] log_p[$], log_i[$];
   bit          log_fc[$], log_lc[$], log_last[$];

   function automatic void build();
      int lim[4];
      int v[4];
      int ord[4];
      int n, r;
      tile_t t;
      lim[0] = int'(lims_s.x); lim[1] = int'(lims_s.y);
      lim[2] = int'(lims_s.k); lim[3] = int'(lims_s.c);
      if (i_order == 1'b0) ord = '{3, 0, 1, 2};
      else                 ord = '{0, 1, 3, 2};
      n = 1;
      for (int d = 0; d < 4; d++) n = n * (lim[d] + 1);
      exp_q.delete();
      for (int idx = 0; idx < n; idx++) begin
         r = idx;
         for (int j = 0; j < 4; j++) begin
            v[ord[j]] = r % (lim[ord[j]] + 1);
            r = r / (lim[ord[j]] + 1);
         end
         t.p = pb + 32'(v[0]) * steps_s.psums[0] + 32'(v[1]) * steps_s.psums[1]
                  + 32'(v[2]) * steps_s.psums[2];
         t.i = ib + 32'(v[0]) * steps_s.ifmaps[0] + 32'(v[1]) * steps_s.ifmaps[1]
                  + 32'(v[3]) * steps_s.ifmaps[2];
         t.w = wb + 32'(v[2]) * steps_s.weights[0] + 32'(v[3]) * steps_s.weights[1];
         t.fc = (v[3] == 0);
         t.lc = (v[3] == lim[3]);
         exp_q.push_back(t);
      end
   endfunction

   function automatic logic [31:0] exp_stall();
`ifdef DF_TILE_ITER_PERF_EN
      return m_stall;
`else
      return 32'd0;
`endif
   endfunction

   // Compare on the falling edge, then advance the model to what the next
   // rising edge will do with the inputs now applied.
   always @(negedge clk) begin
      if (i_rst) begin
         chk("rst_valid", o_valid, 0);
         chk("rst_busy", o_busy, 0);
         chk("rst_done", o_done, 0);
         chk("rst_addr", {o_psums_addr, o_ifmaps_addr}, 0);
         chk("rst_flags", {o_first_c, o_last_c, o_last, o_weights_addr}, 0);
         chk("rst_stall", o_stall_cnt, 0);
         phase = 0;
         exp_q.delete();
         m_stall = '0;
      end else begin
         chk("busy", o_busy, phase != 0);
         chk("valid", o_valid, phase == 1);
         chk("done", o_done, phase == 2);
         chk("stall_cnt", o_stall_cnt, exp_stall());
         if (o_done) done_cnt++;
         if (phase == 1 && exp_q.size() > 0) begin
            chk("psums_addr", o_psums_addr, exp_q[0].p);
            chk("ifmaps_addr", o_ifmaps_addr, exp_q[0].i);
            chk("weights_addr", o_weights_addr, exp_q[0].w);
            chk("first_c", o_first_c, exp_q[0].fc);
            chk("last_c", o_last_c, exp_q[0].lc);
            chk("last", o_last, exp_q.size() == 1);
         end
         case (phase)
            0: if (i_start) begin
               build();
               phase = 1;
               m_stall = '0;
            end
            1: begin
               if (!i_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
               if (i_abort) begin
                  phase = 0;
                  exp_q.delete();
               end else if (i_ready) begin
                  log_p.push_back(o_psums_addr);
                  log_i.push_back(o_ifmaps_addr);
                  log_fc.push_back(o_first_c);
                  log_lc.push_back(o_last_c);
                  log_last.push_back(o_last);
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
                  if (exp_q.size() == 0) phase = 2;
               end
            end
            default: phase = 0;
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input bit ord, input int lx, input int ly, input int lk, input int lc);
      i_order  = ord;
      lims_s.x = 16'(lx);
      lims_s.y = 16'(ly);
      lims_s.k = 16'(lk);
      lims_s.c = 16'(lc);
   endtask

   task automatic clear_log();
      log_p.delete(); log_i.delete(); log_fc.delete(); log_lc.delete(); log_last.delete();
   endtask

   task automatic start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic run_until_idle(input int ready_pct, input bit chaos);
      for (int k = 0; k < 4000; k++) begin
         if (!o_busy) break;
         i_ready = ($urandom_range(0, 99) < ready_pct);
         if (chaos) begin
            i_start = ($urandom_range(0, 7) == 0);
            i_abort = ($urandom_range(0, 80) == 0);
            i_order = 1'($urandom);
            lims_s  = {$urandom, $urandom};
            pb      = $urandom;
         end
         tick();
      end
      i_start = 1'b0;
      i_abort = 1'b0;
      i_ready = 1'b0;
      chk("walk_timeout", o_busy, 0);
   endtask

   logic [31:0] e2[6], e3[6];
   logic [5:0]  fc2, lc2, fc3, lc3;
   int          dc;

   initial begin
      e2 = '{32'h0, 32'h100, 32'h200, 32'h1000, 32'h1100, 32'h1200};
      e3 = '{32'h0, 32'h1000, 32'h100, 32'h1100, 32'h200, 32'h1200};
      fc2 = 6'b001001; lc2 = 6'b100100;
      fc3 = 6'b000011; lc3 = 6'b110000;

      repeat (2) tick();
      i_rst = 1'b0;
      tick();

      // T1: x,y walk over psums, always ready
      pb = 32'h1000; ib = 32'h2000; wb = 32'h3000;
      steps_s = '0;
      steps_s.psums[0] = 32'd4; steps_s.psums[1] = 32'd16; steps_s.psums[2] = 32'h40;
      cfg(0, 1, 1, 0, 0);
      clear_log();
      dc = done_cnt;
      start();
      chk("t1_first_valid", o_valid, 1);
      chk("t1_first_addr", o_psums_addr, 32'h1000);
      run_until_idle(100, 0);
      chk("t1_ntiles", log_p.size(), 4);
      chk("t1_a0", log_p[0], 32'h1000);
      chk("t1_a1", log_p[1], 32'h1004);
      chk("t1_a2", log_p[2], 32'h1010);
      chk("t1_a3", log_p[3], 32'h1014);
      chk("t1_last_early", log_last[2], 0);
      chk("t1_last_final", log_last[3], 1);
      chk("t1_done_pulses", done_cnt - dc, 1);

      // T2/T3: c and x with both loop orders
      ib = 32'h0;
      steps_s.ifmaps[0] = 32'h1000; steps_s.ifmaps[1] = 32'h0; steps_s.ifmaps[2] = 32'h100;
      for (int o = 0; o < 2; o++) begin
         cfg(1'(o), 1, 0, 0, 2);
         clear_log();
         start();
         run_until_idle(100, 0);
         chk("t23_ntiles", log_i.size(), 6);
         for (int n = 0; n < 6; n++) begin
            chk(o == 0 ? "t2_ifmaps" : "t3_ifmaps", log_i[n], o == 0 ? e2[n] : e3[n]);
            chk(o == 0 ? "t2_first_c" : "t3_first_c", log_fc[n], o == 0 ? fc2[n] : fc3[n]);
            chk(o == 0 ? "t2_last_c" : "t3_last_c", log_lc[n], o == 0 ? lc2[n] : lc3[n]);
         end
      end

      // T4: back-pressure at tile 2 for 5 cycles
      cfg(0, 1, 1, 0, 0);
      start();
      i_ready = 1'b1;
      tick();
      tick();
      i_ready = 1'b0;
      repeat (5) tick();
      chk("t4_held_addr", o_psums_addr, 32'h1010);
`ifdef DF_TILE_ITER_PERF_EN
      chk("t4_stall_cnt", o_stall_cnt, 32'd5);
`else
      chk("t4_stall_cnt", o_stall_cnt, 32'd0);
`endif
      run_until_idle(100, 0);

      // T5: abort wins over a same-cycle handshake, then restart from tile 0
      cfg(0, 1, 0, 0, 2);
      dc = done_cnt;
      start();
      i_ready = 1'b1;
      tick();
      tick();
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      i_ready = 1'b0;
      chk("t5_abort_busy", o_busy, 0);
      chk("t5_abort_valid", o_valid, 0);
      tick();
      chk("t5_no_done", done_cnt - dc, 0);
      start();
      chk("t5_restart_addr", o_ifmaps_addr, 32'h0);
      chk("t5_restart_first_c", o_first_c, 1);
      run_until_idle(100, 0);

      // T6: single tile and address wraparound
      pb = 32'hFFFF_FFFC;
      steps_s = '0;
      steps_s.psums[0] = 32'd8; steps_s.psums[1] = 32'd8; steps_s.psums[2] = 32'd8;
      cfg(0, 0, 0, 0, 0);
      clear_log();
      start();
      chk("t6_addr", o_psums_addr, 32'hFFFF_FFFC);
      chk("t6_flags", {o_valid, o_first_c, o_last_c, o_last}, 4'b1111);
      run_until_idle(100, 0);
      chk("t6_ntiles", log_p.size(), 1);
      cfg(0, 1, 0, 0, 0);
      clear_log();
      start();
      run_until_idle(100, 0);
      chk("t6_wrap_addr", log_p[1], 32'h0000_0004);

      // T7: reset in the middle of a walk
      cfg(1, 2, 2, 1, 1);
      start();
      i_ready = 1'b1;
      repeat (3) tick();
      i_rst = 1'b1;
      #1;
      chk("t7_rst_valid", o_valid, 0);
      chk("t7_rst_busy", o_busy, 0);
      tick();
      i_rst = 1'b0;
      i_ready = 1'b0;
      tick();

      // Random walks, half of them with config noise, stray starts and aborts
      for (int n = 0; n < 40; n++) begin
         cfg(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3));
         pb = $urandom; ib = $urandom; wb = $urandom;
         steps_s = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
         start();
         run_until_idle(70, n[0]);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/df_tile_iter.md
Name: df_tile_iter

Overview:
- Parametrised tile-loop walker for the dataflow controller.
- Given per-dimension limits (x, y, k, c) and per-stream steps, it emits one tile descriptor per accepted handshake: psums/ifmaps/weights base addresses plus reduction flags.
- Supports two selectable loop orders. Feeds the DMA sequencer and replaces hand-sequenced tile stepping in software.

Parameters:
- ADDR_W, 32, width of step, base and address values.
- CNT_W, 16, width of loop limits and counters.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  one-cycle start pulse; ignored unless IDLE
- i_abort  in  1  return to IDLE, no done pulse
- i_order  in  1  0 = c innermost (c,x,y,k); 1 = c outer (x,y,c,k); innermost listed first
- i_lim  in  4*CNT_W  last index of {c,k,y,x} (MSB..LSB); 0 means one iteration
- i_psums_base, i_ifmaps_base, i_weights_base  in  ADDR_W each  stream base addresses
- i_psums_step  in  3*ADDR_W  {k,y,x} steps
- i_ifmaps_step  in  3*ADDR_W  {c,y,x} steps
- i_weights_step  in  2*ADDR_W  {c,k} steps
- o_valid  out  1  tile descriptor valid
- i_ready  in  1  consumer accepts descriptor
- o_psums_addr, o_ifmaps_addr, o_weights_addr  out  ADDR_W each  tile addresses
- o_first_c  out  1  c counter == 0 (psum preload not needed)
- o_last_c  out  1  c counter == c_lim (psum writeback)
- o_last  out  1  final tile of the walk
- o_busy  out  1  not IDLE
- o_done  out  1  one-cycle pulse after final handshake
- o_stall_cnt  out  32  see Optional Feature

Behaviour:
- Reset: all outputs 0; state IDLE; counters/offsets 0.
- States: IDLE, RUN, DONE.
  - IDLE + i_start (cycle t): latch all config, clear counters/offsets → RUN. At t+1: o_valid=1 with tile (0,0,0,0); addresses = bases.
  - RUN: descriptor held stable while o_valid & !i_ready.
  - On handshake with !o_last: next tile presented at the next cycle, with no bubble.
  - On handshake with o_last: o_valid→0, go to DONE.
  - DONE: o_done=1 for one cycle → IDLE.
- i_abort in RUN or DONE: IDLE next cycle, o_valid=0, o_done=0. i_abort has priority over a same-cycle handshake.
- i_start while busy: ignored. Config changes after start: ignored until the next start.
- Counter advance on handshake:
  - Innermost dim increments.
  - A dim at its lim wraps to 0 and carries into the next dim outward.
  - o_last = all counters at lim.
- Addresses are incremental; no multipliers. Each stream keeps one offset register per relevant dim:
  - increment: offset += step
  - wrap: offset = 0
- Output address = base + sum of that stream's offsets. Registered, modulo 2^ADDR_W; overflow silently wraps.
- Dims a stream does not use (psums:c, ifmaps:k, weights:x,y) do not affect that stream's address.
- All lim = 0: single tile; o_first_c = o_last_c = o_last = 1 at t+1.
- Reset mid-walk: immediate IDLE, outputs 0.

Optional Feature:
- Macro DF_TILE_ITER_PERF_EN.
- Defined: o_stall_cnt counts cycles with o_valid & !i_ready. Cleared on i_start. Saturates at 2^32-1.
- Undefined: o_stall_cnt tied to 0; no counter register.

Decomposition:
- df_ctrl_pkg gains:
  - loop-order enum (LOOP_C_INNER = 0, LOOP_C_OUTER = 1)
  - TileIterLims struct {x,y,k,c} of CNT_W
  - TileIterSteps struct grouping per-stream steps
  - localparam NUM_TILE_DIMS = 4
- One sub-module: df_loop_cnt. It holds one dimension's counter, wrap detect, carry-out and per-stream offset accumulators. Instantiated four times; the carry chain order is muxed by i_order.

Test Plan:
- lim x=1,y=1,k=0,c=0; psums steps x=4,y=16; order 0; i_ready=1 → psums addrs base+{0,4,16,20} on 4 consecutive cycles; o_last on the 4th; o_done one cycle later.
- lim c=2, x=1, order 0, ifmaps c_step=0x100 → ifmaps offsets 0,0x100,0x200,0,...; o_first_c on tiles 0 and 3; o_last_c on tiles 2 and 5.
- Same config with order 1 → x wraps first: tile sequence (x,c) = (0,0),(1,0),(0,1),(1,1),(0,2),(1,2).
- i_ready low 5 cycles at tile 2 → descriptor stable all 5 cycles; o_stall_cnt=5 with DF_TILE_ITER_PERF_EN, 0 without.
- Assert i_abort mid-walk, then i_start → walk restarts at tile (0,0,0,0); no o_done from the aborted walk.
- All lim=0, base 0xFFFF_FFFC, step 8 → single tile at 0xFFFF_FFFC with flags set. Then separately, lim x=1 → second address wraps to 0x0000_0004.
